// File: rtl/count_down_timer_pkg.sv
// rtl/count_down_timer_pkg.sv - shared state encoding and 7-segment constants for the countdown timer
package count_down_timer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low {dp,g,f,e,d,c,b,a}; element 0 is the pattern for digit 0.
    localparam logic [9:0][7:0] DIGIT_CODES = {
        8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
        8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

endpackage

// File: rtl/count_down_timer_if.sv
// rtl/count_down_timer_if.sv - level/start/timebase inputs and display/done outputs of the timer
interface count_down_timer_if;
    logic       Clk1Hz;
    logic [3:0] curLevel;
    logic       start;
    logic       doneCounting;
    logic [7:0] seg0;
    logic [7:0] seg1;

    modport master (
        output Clk1Hz, curLevel, start,
        input  doneCounting, seg0, seg1
    );

    modport slave (
        input  Clk1Hz, curLevel, start,
        output doneCounting, seg0, seg1
    );
endinterface

// File: rtl/count_down_timer_seg7_decode.sv
// rtl/count_down_timer_seg7_decode.sv - 4-bit digit to active-low 7-segment pattern, blank above 9
module seg7_decode
    import count_down_timer_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [7:0] seg_o
);
    always_comb begin
        seg_o = SEG_BLANK;
        if (digit_i <= 4'd9) begin
            seg_o = DIGIT_CODES[digit_i];
        end
    end
endmodule

// File: rtl/count_down_timer.sv
// rtl/count_down_timer.sv - level-scaled seconds countdown with two-digit display and done pulse
module count_down_timer
    import count_down_timer_pkg::*;
#(
    parameter int unsigned BASE_SECONDS = 20,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic              Clk100M,
    input  logic              Rst_n,
    count_down_timer_if.slave bus
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev_q;
    logic                   tick_q;
    logic                   start_q;
    logic                   start_edge;
    state_e                 state_q, state_d;
    logic [6:0]             count_q, count_d;
    logic                   done_q, done_d;
    logic [7:0]             seg0_q, seg0_d;
    logic [7:0]             seg1_q, seg1_d;
    logic [6:0]             rem;
    logic [3:0]             ones_digit;
    logic [3:0]             tens_digit;
    logic [7:0]             ones_code;
    logic [7:0]             tens_code;

    assign start_edge = bus.start & ~start_q;

    // Clk1Hz is treated purely as asynchronous data; the tick is registered after edge detection.
    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) begin
            sync_q      <= '0;
            sync_prev_q <= 1'b0;
            tick_q      <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            sync_q[0] <= bus.Clk1Hz;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            sync_prev_q <= sync_q[SYNC_STAGES-1];
            tick_q      <= sync_q[SYNC_STAGES-1] & ~sync_prev_q;
            start_q     <= bus.start;
        end
    end

    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
            seg0_q  <= SEG_BLANK;
            seg1_q  <= SEG_BLANK;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
            seg0_q  <= seg0_d;
            seg1_q  <= seg1_d;
        end
    end

    // A start edge always wins over a coincident tick.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;
        if (start_edge) begin
            count_d = 7'(BASE_SECONDS) - {3'b000, bus.curLevel};
            state_d = RUN;
        end else if (state_q == RUN && tick_q) begin
            if (count_q > 7'd1) begin
                count_d = count_q - 7'd1;
            end else begin
                count_d = '0;
                state_d = DONE;
                done_d  = 1'b1;
            end
        end
    end

    // count never exceeds 99, so nine conditional subtractions split tens from ones.
    always_comb begin
        rem        = count_q;
        tens_digit = '0;
        for (int i = 0; i < 9; i++) begin
            if (rem >= 7'd10) begin
                rem        = rem - 7'd10;
                tens_digit = tens_digit + 4'd1;
            end
        end
        ones_digit = 4'(rem);
    end

    seg7_decode u_ones (.digit_i(ones_digit), .seg_o(ones_code));
    seg7_decode u_tens (.digit_i(tens_digit), .seg_o(tens_code));

    always_comb begin
        seg0_d = SEG_BLANK;
        seg1_d = SEG_BLANK;
        if (state_q != IDLE) begin
            seg0_d = ones_code;
            if (count_q >= 7'd10) begin
                seg1_d = tens_code;
            end
        end
    end

    assign bus.doneCounting = done_q;
    assign bus.seg0         = seg0_q;
    assign bus.seg1         = seg1_q;
endmodule

// File: tb/tb_count_down_timer.sv
// tb/tb_count_down_timer.sv - self-checking bench for count_down_timer
module tb_count_down_timer;
    localparam int BASE = 20;
    localparam int SS   = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    count_down_timer_if bus();

    count_down_timer #(.BASE_SECONDS(BASE), .SYNC_STAGES(SS)) dut (
        .Clk100M(clk),
        .Rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   done_cnt = 0;
    int   done_cyc = -1;
    int   dbl      = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.doneCounting === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            if (prev_done) dbl++;
        end
        prev_done = bus.doneCounting;
    end

    typedef struct {
        string      name;
        logic [7:0] s0;
        logic [7:0] s1;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        int         level;
        logic [7:0] s0;
        logic [7:0] s1;
    } vec_t;

    function automatic logic [7:0] code(input int d);
        logic [7:0] t [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        return t[d];
    endfunction

    task automatic push_disp(input string n, input int cnt);
        exp_t e;
        e.name = n;
        e.s0   = code(cnt % 10);
        e.s1   = (cnt >= 10) ? code(cnt / 10) : 8'hFF;
        sbq.push_back(e);
    endtask

    task automatic push_blank(input string n);
        exp_t e;
        e.name = n;
        e.s0   = 8'hFF;
        e.s1   = 8'hFF;
        sbq.push_back(e);
    endtask

    task automatic check_disp();
        exp_t e;
        @(negedge clk);
        e = sbq.pop_front();
        checks++;
        if (bus.seg0 !== e.s0 || bus.seg1 !== e.s1) begin
            errors++;
            $display("FAIL %s: seg1/seg0=%h/%h expected %h/%h", e.name, bus.seg1, bus.seg0, e.s1, e.s0);
        end
    endtask

    task automatic check_int(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int level);
        cycles(1);
        bus.curLevel = 4'(level);
        bus.start    = 1'b1;
        cycles(1);
        bus.start    = 1'b0;
        cycles(1);
    endtask

    task automatic one_sec();
        bus.Clk1Hz = 1'b1;
        cycles(8);
        bus.Clk1Hz = 1'b0;
        cycles(8);
    endtask

    vec_t vecs[6];
    int   d0;
    int   c0;

    initial begin
        vecs[0] = '{0,  8'hC0, 8'hA4};
        vecs[1] = '{3,  8'hF8, 8'hF9};
        vecs[2] = '{9,  8'hF9, 8'hF9};
        vecs[3] = '{10, 8'hC0, 8'hF9};
        vecs[4] = '{11, 8'h90, 8'hFF};
        vecs[5] = '{15, 8'h92, 8'hFF};

        bus.Clk1Hz   = 1'b0;
        bus.curLevel = 4'd0;
        bus.start    = 1'b0;
        cycles(3);
        push_blank("reset_blank");
        check_disp();
        check_int("reset_done", int'(bus.doneCounting), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        one_sec();
        push_blank("idle_blank");
        check_disp();

        // Table of loads: each start edge in RUN reloads immediately without a done pulse.
        for (int i = 0; i < 6; i++) begin
            pulse_start(vecs[i].level);
            begin
                exp_t e;
                e.name = $sformatf("load_level_%0d", vecs[i].level);
                e.s0   = vecs[i].s0;
                e.s1   = vecs[i].s1;
                sbq.push_back(e);
            end
            check_disp();
        end
        check_int("no_done_on_reload", done_cnt, 0);

        // Level 0 full run.
        pulse_start(0);
        push_disp("full_load", 20);
        check_disp();
        for (int i = 1; i < 20; i++) begin
            one_sec();
            push_disp($sformatf("full_count_%0d", 20 - i), 20 - i);
            check_disp();
        end
        cycles(1);
        d0 = done_cnt;
        c0 = cyc;
        one_sec();
        check_int("full_done_pulses", done_cnt - d0, 1);
        check_int("full_done_latency", done_cyc - c0, SS + 2);
        push_disp("full_done_disp", 0);
        check_disp();

        // Level 15 short run, then extra tick in DONE.
        pulse_start(15);
        push_disp("short_load", 5);
        check_disp();
        d0 = done_cnt;
        for (int i = 0; i < 4; i++) one_sec();
        push_disp("short_count_1", 1);
        check_disp();
        one_sec();
        check_int("short_done_pulses", done_cnt - d0, 1);
        one_sec();
        check_int("short_no_extra_pulse", done_cnt - d0, 1);
        push_disp("short_done_hold", 0);
        check_disp();

        // Restart from DONE.
        pulse_start(14);
        push_disp("redone_load", 6);
        check_disp();
        d0 = done_cnt;
        for (int i = 0; i < 6; i++) one_sec();
        check_int("redone_second_pulse", done_cnt - d0, 1);

        // Restart in RUN at count 7 with held start.
        pulse_start(10);
        for (int i = 0; i < 3; i++) one_sec();
        push_disp("restart_at_7", 7);
        check_disp();
        d0 = done_cnt;
        cycles(1);
        bus.curLevel = 4'd10;
        bus.start    = 1'b1;
        cycles(2);
        push_disp("restart_reload", 10);
        check_disp();
        cycles(1);
        one_sec();
        one_sec();
        cycles(66);
        push_disp("held_start_no_reload", 8);
        check_disp();
        cycles(1);
        bus.start = 1'b0;
        check_int("restart_no_done", done_cnt - d0, 0);

        // Collision of start edge with tick at count 3.
        pulse_start(15);
        one_sec();
        one_sec();
        push_disp("collide_pre", 3);
        check_disp();
        cycles(1);
        d0 = done_cnt;
        bus.Clk1Hz = 1'b1;
        cycles(3);
        bus.curLevel = 4'd4;
        bus.start    = 1'b1;
        cycles(1);
        bus.start    = 1'b0;
        cycles(6);
        bus.Clk1Hz   = 1'b0;
        cycles(8);
        push_disp("collide_load", 16);
        check_disp();
        cycles(1);
        bus.curLevel = 4'd0;
        one_sec();
        push_disp("level_change_ignored", 15);
        check_disp();
        check_int("collide_no_done", done_cnt - d0, 0);

        // Reset mid-run at count 12.
        pulse_start(8);
        push_disp("pre_reset_12", 12);
        check_disp();
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        check_int("async_reset_seg0", int'(bus.seg0), 8'hFF);
        check_int("async_reset_seg1", int'(bus.seg1), 8'hFF);
        check_int("async_reset_done", int'(bus.doneCounting), 0);
        cycles(2);
        rst_n = 1'b1;
        one_sec();
        one_sec();
        push_blank("post_reset_idle");
        check_disp();

        check_int("done_never_double", dbl, 0);
        check_int("scoreboard_drained", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
